// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Synchronizes and glitch-filters ps2_clk/ps2_data, then shifts in one
// 11-bit frame: start, 8 data bits LSB-first, odd parity, stop.
// Good bytes appear on data with a one-cycle valid pulse; parity, stop or
// timeout failures give a one-cycle err pulse.
// Build option: define PS2_RX_TIMEOUT_EN to build the mid-frame watchdog
// clocked by tick; without it tick is unused and a stalled frame waits for
// further edges or rst.
module ps2_rx #(
  parameter int unsigned FILTER_LEN    = 8,
  parameter int unsigned TIMEOUT_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                  clk_s1, clk_s2;
  logic                  dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  fe;
  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;
  logic                  par_ok;
  logic                  to_hit;

  // Two-stage synchronizers for both pins; idle-high reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock glitch filter with hysteresis; fe is registered alongside filt_clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_sr  <= '1;
      filt_clk <= 1'b1;
      fe       <= 1'b0;
    end else begin
      filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
      if (filt_sr == '0) begin
        filt_clk <= 1'b0;
        fe       <= filt_clk;
      end else if (&filt_sr) begin
        filt_clk <= 1'b1;
        fe       <= 1'b0;
      end else begin
        fe       <= 1'b0;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt;

  // The tick that would bring the count to TIMEOUT_TICKS aborts the frame
  assign to_hit = (state != S_IDLE) && tick &&
                  (to_cnt == CNT_W'(TIMEOUT_TICKS - 1));

  // Watchdog: counts ticks since the last filtered falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((state == S_IDLE) || fe || to_hit) begin
      to_cnt <= '0;
    end else if (tick) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_tick;

  assign unused_tick = tick;
  assign to_hit      = 1'b0;
`endif

  // Frame FSM with registered data/valid/err/busy; an edge beats a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_ok  <= 1'b0;
      data    <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (fe) begin
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
              busy    <= 1'b1;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end
          end
          S_PARITY: begin
            par_ok <= (^shreg) ^ dat_s2;
            state  <= S_STOP;
          end
          S_STOP: begin
            if (dat_s2 && par_ok) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              err   <= 1'b1;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (to_hit) begin
        err   <= 1'b1;
        state <= S_IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: self-checking bench for ps2_rx. Frames are driven at the pin
// level; expectations come from a byte-level model of the frame rules.
module tb_ps2_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 100;
  localparam int          HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_pulse_cyc = -1;
  int fall_cyc = 0;
  logic [7:0] exp_data = 8'h00;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_TICKS(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .valid    (valid),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts valid/err pulses and their cycle
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      last_pulse_cyc = cyc;
    end
    if (err) begin
      n_err++;
      last_pulse_cyc = cyc;
    end
    if (valid || err) begin
      total++;
      if (valid && err) begin
        bad++;
        $display("FAIL valid_err_exclusive: valid=%b err=%b at cyc %0d, required not both", valid, err, cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data changes while clock is high; device falls clock mid-bit
  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(s);
    ps2_data = 1'b1;
  endtask

  // Sends one frame and checks the outcome against the frame rules
  task automatic check_frame(input string name, input logic [7:0] b, input logic p, input logic s);
    int   v0;
    int   e0;
    int   ones;
    logic ok;
    v0   = n_valid;
    e0   = n_err;
    ones = $countones(b) + int'(p);
    ok   = ((ones % 2) == 1) && s;
    send_frame(b, p, s);
    wait_cyc(FL + 8);
    if (ok) exp_data = b;
    total++;
    if ((n_valid - v0) !== (ok ? 1 : 0)) begin
      bad++;
      $display("FAIL %s valid_count: got %0d required %0d", name, n_valid - v0, ok ? 1 : 0);
    end
    total++;
    if ((n_err - e0) !== (ok ? 0 : 1)) begin
      bad++;
      $display("FAIL %s err_count: got %0d required %0d", name, n_err - e0, ok ? 0 : 1);
    end
    total++;
    if (data !== exp_data) begin
      bad++;
      $display("FAIL %s data: got %02h required %02h", name, data, exp_data);
    end
    total++;
    if (last_pulse_cyc !== fall_cyc + int'(FL) + 4) begin
      bad++;
      $display("FAIL %s latency: pulse at %0d required %0d", name, last_pulse_cyc, fall_cyc + int'(FL) + 4);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after: got %b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tick     = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(4);
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h required 00", data); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", valid); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", err); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst = 1'b0;
    wait_cyc(30);
    total++;
    if ((n_valid + n_err) !== 0) begin
      bad++;
      $display("FAIL reset_release_pulses: got %0d required 0", n_valid + n_err);
    end
  endtask

  task automatic test_good();
    check_frame("good_1c", 8'h1C, 1'b0, 1'b1);
  endtask

  task automatic test_bad_parity();
    check_frame("bad_parity_f0", 8'hF0, 1'b0, 1'b1);
  endtask

  task automatic test_stop_err();
    check_frame("stop_err_55", 8'h55, 1'b1, 1'b0);
    check_frame("after_stop_aa", 8'hAA, 1'b1, 1'b1);
  endtask

  task automatic test_glitch();
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    ps2_data = 1'b0;
    wait_cyc(5);
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(FL - 1);
      ps2_clk = 1'b1;
      wait_cyc(FL + 6);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL glitch_busy_%0d: got %b required 0", g, busy);
      end
    end
    ps2_data = 1'b1;
    send_bit(1'b1);
    wait_cyc(FL + 8);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL false_start_busy: got %b required 0", busy); end
    total++;
    if ((n_valid - v0) + (n_err - e0) !== 0) begin
      bad++;
      $display("FAIL glitch_pulses: got %0d required 0", (n_valid - v0) + (n_err - e0));
    end
  endtask

`ifdef PS2_RX_TIMEOUT_EN
  task automatic test_timeout();
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1)));
    ps2_data = 1'b1;
    for (int i = 0; i < 400 && n_err == e0; i++) @(negedge clk);
    wait_cyc(3);
    total++;
    if ((n_err - e0) !== 1) begin
      bad++;
      $display("FAIL timeout_err_count: got %0d required 1", n_err - e0);
    end
    total++;
    if (last_pulse_cyc !== fall_cyc + int'(FL) + 3 + int'(TO) + 1) begin
      bad++;
      $display("FAIL timeout_time: pulse at %0d required %0d", last_pulse_cyc, fall_cyc + int'(FL) + 4 + int'(TO));
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b required 0", busy); end
    total++;
    if (n_valid !== v0) begin bad++; $display("FAIL timeout_valid: got %0d required %0d", n_valid, v0); end
    check_frame("after_timeout_f0", 8'hF0, 1'b1, 1'b1);
  endtask
`else
  task automatic test_stall();
    int e0;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1)));
    ps2_data = 1'b1;
    wait_cyc(400);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b required 1", busy); end
    total++;
    if (n_err !== e0) begin bad++; $display("FAIL stall_err: got %0d required %0d", n_err, e0); end
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    exp_data = 8'h00;
    wait_cyc(10);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL stall_reset_busy: got %b required 0", busy); end
  endtask
`endif

  task automatic test_reset_mid();
    int          v0;
    int          e0;
    logic [7:0]  b;
    v0 = n_valid;
    e0 = n_err;
    b  = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    rst = 1'b1;
    exp_data = 8'h00;
    wait_cyc(3);
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL midreset_data: got %02h required 00", data); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b required 0", busy); end
    total++;
    if ({valid, err} !== 2'b00) begin bad++; $display("FAIL midreset_pulses: got %b required 00", {valid, err}); end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst      = 1'b0;
    wait_cyc(40);
    total++;
    if ((n_valid - v0) + (n_err - e0) !== 0) begin
      bad++;
      $display("FAIL midreset_release: got %0d pulses required 0", (n_valid - v0) + (n_err - e0));
    end
    check_frame("after_reset_1c", 8'h1C, 1'b0, 1'b1);
  endtask

  // Random bytes with mostly-correct parity and stop; back-to-back frames
  task automatic test_random();
    logic [7:0] b;
    logic       p;
    logic       s;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(3) == 0) p = ~p;
      s = ($urandom_range(4) != 0);
      check_frame("random", b, p, s);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_parity();
    test_stop_err();
    test_glitch();
`ifdef PS2_RX_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host frame receiver. It synchronizes and glitch-filters the raw `ps2_clk`/`ps2_data` pins and shifts in one 11-bit frame: start, 8 data bits LSB-first, odd parity, stop. It presents each good byte as a one-cycle `valid` pulse. It sits directly downstream of the shared `mod` prescaler: that counter's `sync_ovf` drives `tick`, the timebase for the mid-frame timeout watchdog.

## Interface
- `FILTER_LEN`, default 8: number of consecutive equal synchronized `ps2_clk` samples required to change the filtered clock. Minimum 2.
- `TIMEOUT_TICKS`, default 100: number of `tick` pulses with no filtered falling edge, while a frame is in progress, that aborts the frame. Minimum 1.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tick` in 1: single-cycle enable from the upstream `mod` counter's `sync_ovf`, nominally 1 µs period.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous, idle high.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous, idle high.
- `data` out 8: last correctly received byte. Updated only when `valid` asserts.
- `valid` out 1: one-cycle pulse, good frame received.
- `err` out 1: one-cycle pulse, frame aborted by parity error, stop error or timeout.
- `busy` out 1: high while state ≠ IDLE.

## Operation
- **Synchronizer:** both pins pass through a 2-FF synchronizer. Reset value is 1.
- **Clock filter:** a `FILTER_LEN`-bit shift register of synchronized `ps2_clk`.
  - `filt_clk` <= 0 when all bits are 0, <= 1 when all bits are 1, otherwise it holds.
  - Filter and `filt_clk` reset to all-ones, so reset produces no spurious edge.
- **Edge detect:** registered `fe` = previous `filt_clk` & ~`filt_clk`. Each action below occurs on a cycle with `fe`=1, using the synchronized `ps2_data` sampled in that cycle.
- **FSM** (reset to IDLE):
  - IDLE: on `fe`, if data=0 go to DATA with bit count 0. If data=1 (false start), stay in IDLE with no `err`.
  - DATA: shift data into bit 7 of the shift register, shifting right. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit. Parity is OK when the XOR of 8 data bits and the parity bit equals 1. Go to STOP.
  - STOP: if data=1 and parity OK, then `data` <= shift register and `valid`=1. Otherwise `err`=1. `data` is unchanged on error. Return to IDLE.
- **Outputs:** `valid` and `err` are registered, never both high, and fire in the cycle after the stop-bit `fe`.
- **Timeout counter:** width `$clog2(TIMEOUT_TICKS+1)`.
  - Cleared in IDLE and on every `fe`.
  - Increments on `tick` when not IDLE.
  - When it reaches `TIMEOUT_TICKS`: `err`=1 for one cycle, FSM goes to IDLE, partial byte discarded.
  - If `fe` and the timeout condition fall in the same cycle, `fe` wins: the counter clears and the frame continues.
- **Reset mid-frame:** all state clears immediately. No `valid` or `err` is generated on release.
- **Output reset values:** `data`=0x00, `valid`=0, `err`=0, `busy`=0.

## Timing
- Latency from a raw `ps2_clk` falling edge to `valid`/`err` is exactly `FILTER_LEN`+4 clk cycles:
  - 2 cycles synchronizer
  - `FILTER_LEN` cycles filter
  - 1 cycle `fe`
  - 1 cycle output register
- `busy` rises 1 cycle after the start-bit `fe` and falls in the same cycle `valid`/`err` asserts.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no edge.
- Minimum supported spacing between `ps2_clk` edges is `FILTER_LEN`+2 cycles.
- `tick` may be held constantly high for simulation. The timeout then counts in clk cycles.

## Configuration
- `PS2_RX_TIMEOUT_EN`:
  - Defined: the watchdog above is built.
  - Undefined: no timeout counter is built, `tick` is unused, and a stalled frame holds `busy` high until the next edges or `rst`.
  - Undefined: all other behaviour is identical.

## Test plan
- **Good frame:** send 0x1C, parity 0, stop 1 -> one `valid` pulse at `FILTER_LEN`+4 cycles after the stop edge; `data`=0x1C; `err` stays 0.
- **Bad parity:** send 0xF0 with parity 0 (correct is 1) -> one `err` pulse; no `valid`; `data` keeps its previous value 0x1C.
- **Stop error:** send 0x55, parity 1, stop 0 -> `err` pulse, no `valid`, FSM in IDLE. A following good 0xAA frame -> `valid`, `data`=0xAA.
- **Glitch and false start:**
  - `ps2_clk` low pulses of `FILTER_LEN`-1 cycles -> no state change, `busy`=0.
  - A falling edge with `ps2_data`=1 -> stays IDLE, no `err`.
- **Timeout** (`PS2_RX_TIMEOUT_EN` defined, `TIMEOUT_TICKS`=100): send start plus 3 bits, then hold lines high -> `err` pulse on the 100th `tick` after the last edge, `busy`=0. The next frame 0xF0 (parity 1) -> `valid`, `data`=0xF0.
- **Reset mid-frame:** assert `rst` after 5 data bits -> all outputs at reset values, no pulses. After release, a full 0x1C frame -> `valid`, `data`=0x1C.
